memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage: EX/MEM register, word-addressed data memory, MEM/WB register.
- Captures execute-stage outputs (ALU result, store data, destination register, RegWrite/MemToReg/MemWrite).
- Performs the load or store, then presents the write-back result, destination register and write enable to the register file.
- Exposes MEM-stage destination/result for the hazard/forwarding unit.

Parameters:
ADDR_WIDTH, 10, number of word-address bits; memory depth = 2**ADDR_WIDTH words of 32 bits

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous reset, active-low
Stall  input  1  hold both pipeline registers; suppress store
Flush  input  1  load a bubble into EX/MEM
RegWrite  input  1  from execute stage
MemToReg  input  1  from execute stage
MemWrite  input  1  from execute stage
ALUResult  input  32  byte address or ALU result from execute stage
WriteData  input  32  store data from execute stage
WriteReg  input  5  destination register from execute stage
ALUResultMem  output  32  EX/MEM-registered ALU result (forwarding)
WriteRegMem  output  5  EX/MEM-registered destination
RegWriteMem  output  1  EX/MEM-registered RegWrite
AddrError  output  1  MEM-stage access misaligned or out of range
RegWriteWB  output  1  register-file write enable
WriteRegWB  output  5  register-file write address
ResultWB  output  32  register-file write data

Behaviour:
- Reset (RST_N=0, asynchronous): all EX/MEM and MEM/WB fields clear to 0, so every output is 0. Memory array is not reset. Reset mid-store cancels the store.
- EX/MEM register, per rising CLK edge:
  - Flush=1: load a bubble (RegWrite, MemToReg, MemWrite = 0; data fields = 0).
  - Otherwise Stall=1: hold.
  - Otherwise: capture the inputs.
  - Flush has priority over Stall.
- Address decode, using the registered ALU result (A):
  - word index = A[ADDR_WIDTH+1:2].
  - Access valid when A[1:0]==0 and A[31:ADDR_WIDTH+2]==0.
  - AddrError = (MemWrite_r | MemToReg_r) & ~valid; combinational from EX/MEM.
- Store: mem[index] <= WriteData_r on the rising edge where MemWrite_r=1, valid=1 and Stall=0 (or Flush=1).
  - Exactly one write per store, even if stalled several cycles.
  - Invalid address: write dropped.
- Load read: combinational from the array, rdata = valid ? mem[index] : 0.
  - A load in the same MEM cycle as a store cannot occur (single port, one instruction per stage).
- MEM/WB register advances on any edge where Stall=0 or Flush=1; holds otherwise. Captures:
  - RegWriteWB <= RegWrite_r & (WriteReg_r != 0)
  - WriteRegWB <= WriteReg_r
  - MemToReg_r, ALUResult_r, rdata
- ResultWB = MemToRegWB ? ReadDataWB : ALUResultWB (combinational from MEM/WB).
- Latency:
  - Inputs present before edge N: ALUResultMem valid after N; store committed at N+1; ResultWB/RegWriteWB valid after N+1.
  - Two-edge latency, throughput 1 per cycle when not stalled.
- Register $0: RegWriteWB is never 1 for WriteRegWB==0.
- Store instructions (RegWrite=0) produce RegWriteWB=0; ResultWB is don't-care but deterministic (equals ALU result).
- A load immediately after a store to the same address: the load reads the new data (store commits at the edge the load enters MEM).

Test Plan:
- Reset: drive inputs non-zero, RST_N=0 between edges -> all outputs 0 immediately, without a clock edge; after release, outputs stay 0 until the first capture.
- Store then load:
  - Store A=0x10, WriteData=0xDEADBEEF.
  - Next cycle, load A=0x10, MemToReg=1, RegWrite=1, WriteReg=8.
  - -> Two edges after the load is presented: RegWriteWB=1, WriteRegWB=8, ResultWB=0xDEADBEEF.
- ALU pass-through: RegWrite=1, MemToReg=0, ALUResult=0x1234, WriteReg=5 -> after 2 edges, ResultWB=0x1234, RegWriteWB=1; after 1 edge, ALUResultMem=0x1234, WriteRegMem=5, RegWriteMem=1.
- Address errors:
  - Store to A=0x12 (misaligned) -> AddrError=1 during MEM cycle; later load of word 0x10 unchanged.
  - Load from A=0x1000 (out of range, ADDR_WIDTH=10) -> ResultWB=0.
- Stall/flush:
  - Store presented, then Stall=1 for 3 cycles with WriteData changed at inputs -> store committed once after Stall drops, with the original data; outputs held during stall.
  - Flush=1 with a RegWrite=1 instruction at inputs -> RegWriteMem=0, and RegWriteWB=0 one edge later.
- $0 suppression: RegWrite=1, WriteReg=0, ALUResult=0x55 -> RegWriteWB=0.

Source files
------------

// File: rtl/memory_stage_if.sv
// Execute-to-memory bus plus the memory stage's forwarding and write-back outputs.
interface memory_stage_if;
    logic        Stall;
    logic        Flush;
    logic        RegWrite;
    logic        MemToReg;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [4:0]  WriteReg;

    logic [31:0] ALUResultMem;
    logic [4:0]  WriteRegMem;
    logic        RegWriteMem;
    logic        AddrError;
    logic        RegWriteWB;
    logic [4:0]  WriteRegWB;
    logic [31:0] ResultWB;

    modport master (
        output Stall, Flush, RegWrite, MemToReg, MemWrite, ALUResult, WriteData, WriteReg,
        input  ALUResultMem, WriteRegMem, RegWriteMem, AddrError, RegWriteWB, WriteRegWB, ResultWB
    );

    modport slave (
        input  Stall, Flush, RegWrite, MemToReg, MemWrite, ALUResult, WriteData, WriteReg,
        output ALUResultMem, WriteRegMem, RegWriteMem, AddrError, RegWriteWB, WriteRegWB, ResultWB
    );
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM register, word-addressed data memory, MEM/WB register.
module memory_stage #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input logic           CLK,
    input logic           RST_N,
    memory_stage_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

    // EX/MEM register
    logic              regwrite_r;
    logic              memtoreg_r;
    logic              memwrite_r;
    logic [DATA_W-1:0] aluresult_r;
    logic [DATA_W-1:0] writedata_r;
    logic [REG_W-1:0]  writereg_r;

    // MEM/WB register
    logic              regwrite_wb;
    logic              memtoreg_wb;
    logic [REG_W-1:0]  writereg_wb;
    logic [DATA_W-1:0] aluresult_wb;
    logic [DATA_W-1:0] readdata_wb;

    logic [DATA_W-1:0] mem [DEPTH];

    logic                  advance_c;
    logic                  addr_valid_c;
    logic                  store_en_c;
    logic [ADDR_WIDTH-1:0] word_idx_c;
    logic [DATA_W-1:0]     rdata_c;

    // A flush pushes the occupant onward even while stalled, so it also retires the MEM slot.
    assign advance_c    = ~bus.Stall | bus.Flush;
    assign word_idx_c   = aluresult_r[ADDR_WIDTH+1:2];
    assign addr_valid_c = (aluresult_r[1:0] == 2'b00) &&
                          (aluresult_r[DATA_W-1:ADDR_WIDTH+2] == '0);
    assign store_en_c   = memwrite_r & addr_valid_c & advance_c;
    assign rdata_c      = addr_valid_c ? mem[word_idx_c] : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            regwrite_r  <= 1'b0;
            memtoreg_r  <= 1'b0;
            memwrite_r  <= 1'b0;
            aluresult_r <= '0;
            writedata_r <= '0;
            writereg_r  <= '0;
        end else if (bus.Flush) begin
            regwrite_r  <= 1'b0;
            memtoreg_r  <= 1'b0;
            memwrite_r  <= 1'b0;
            aluresult_r <= '0;
            writedata_r <= '0;
            writereg_r  <= '0;
        end else if (!bus.Stall) begin
            regwrite_r  <= bus.RegWrite;
            memtoreg_r  <= bus.MemToReg;
            memwrite_r  <= bus.MemWrite;
            aluresult_r <= bus.ALUResult;
            writedata_r <= bus.WriteData;
            writereg_r  <= bus.WriteReg;
        end
    end

    // Store commits only on the edge the instruction leaves MEM, giving one write per store.
    always_ff @(posedge CLK) begin
        if (store_en_c) begin
            mem[word_idx_c] <= writedata_r;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            regwrite_wb  <= 1'b0;
            memtoreg_wb  <= 1'b0;
            writereg_wb  <= '0;
            aluresult_wb <= '0;
            readdata_wb  <= '0;
        end else if (advance_c) begin
            regwrite_wb  <= regwrite_r & (writereg_r != '0);
            memtoreg_wb  <= memtoreg_r;
            writereg_wb  <= writereg_r;
            aluresult_wb <= aluresult_r;
            readdata_wb  <= rdata_c;
        end
    end

    assign bus.ALUResultMem = aluresult_r;
    assign bus.WriteRegMem  = writereg_r;
    assign bus.RegWriteMem  = regwrite_r;
    assign bus.AddrError    = (memwrite_r | memtoreg_r) & ~addr_valid_c;
    assign bus.RegWriteWB   = regwrite_wb;
    assign bus.WriteRegWB   = writereg_wb;
    assign bus.ResultWB     = memtoreg_wb ? readdata_wb : aluresult_wb;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, reset sequence, randomized model check.
module tb_memory_stage;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned MEM_BYTES  = 4 * (2 ** ADDR_WIDTH);

    logic CLK = 1'b0;
    logic RST_N;

    memory_stage_if bus ();

    memory_stage #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        st, fl, rw, mtr, mw;
        logic [31:0] alu, wd;
        logic [4:0]  wr;
        logic [31:0] e_alum;
        logic [4:0]  e_wrm;
        logic        e_rwm, e_err, e_rwwb;
        logic [4:0]  e_wrwb;
        logic [31:0] e_res;
    } vec_t;

    typedef struct {
        logic        rw, mtr, mw;
        logic [31:0] alu, wd;
        logic [4:0]  wr;
    } instr_t;

    vec_t vecs[$];

    // Reference model: the instruction sitting in MEM, the last retired write-back, and memory contents.
    instr_t      occ;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic [31:0] mem_m [int unsigned];

    function automatic vec_t v(input logic st, fl, rw, mtr, mw, input logic [31:0] alu, wd,
                               input logic [4:0] wr, input logic [31:0] e_alum,
                               input logic [4:0] e_wrm, input logic e_rwm, e_err, e_rwwb,
                               input logic [4:0] e_wrwb, input logic [31:0] e_res);
        vec_t r;
        r.st = st; r.fl = fl; r.rw = rw; r.mtr = mtr; r.mw = mw;
        r.alu = alu; r.wd = wd; r.wr = wr;
        r.e_alum = e_alum; r.e_wrm = e_wrm; r.e_rwm = e_rwm; r.e_err = e_err;
        r.e_rwwb = e_rwwb; r.e_wrwb = e_wrwb; r.e_res = e_res;
        return r;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a % 32'd4 == 32'd0) && (a < 32'(MEM_BYTES));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] alum, input logic [4:0] wrm,
                              input logic rwm, err, rwwb, input logic [4:0] wrwb,
                              input logic [31:0] res);
        chk({tag, ".ALUResultMem"}, bus.ALUResultMem, alum);
        chk({tag, ".WriteRegMem"},  32'(bus.WriteRegMem), 32'(wrm));
        chk({tag, ".RegWriteMem"},  32'(bus.RegWriteMem), 32'(rwm));
        chk({tag, ".AddrError"},    32'(bus.AddrError), 32'(err));
        chk({tag, ".RegWriteWB"},   32'(bus.RegWriteWB), 32'(rwwb));
        chk({tag, ".WriteRegWB"},   32'(bus.WriteRegWB), 32'(wrwb));
        chk({tag, ".ResultWB"},     bus.ResultWB, res);
    endtask

    task automatic drive(input logic st, fl, rw, mtr, mw, input logic [31:0] alu, wd,
                         input logic [4:0] wr);
        bus.Stall = st; bus.Flush = fl; bus.RegWrite = rw; bus.MemToReg = mtr;
        bus.MemWrite = mw; bus.ALUResult = alu; bus.WriteData = wd; bus.WriteReg = wr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_step(input bit st, input bit fl, input instr_t x);
        bit          ok;
        int unsigned w;
        if (fl || !st) begin
            ok = in_range(occ.alu);
            w  = occ.alu / 32'd4;
            if (occ.mtr) m_res = ok ? mem_m[w] : 32'd0;
            else         m_res = occ.alu;
            m_we = occ.rw && (occ.wr != 5'd0);
            m_rd = occ.wr;
            if (occ.mw && ok) mem_m[w] = occ.wd;
        end
        if (fl)       occ = '{default: '0};
        else if (!st) occ = x;
    endtask

    task automatic model_check(input string tag);
        check_outs(tag, occ.alu, occ.wr, occ.rw,
                   (occ.mw || occ.mtr) && !in_range(occ.alu), m_we, m_rd, m_res);
    endtask

    task automatic run_model_cycle(input string tag, input bit st, input bit fl, input instr_t x);
        drive(st, fl, x.rw, x.mtr, x.mw, x.alu, x.wd, x.wr);
        tick();
        model_step(st, fl, x);
        model_check(tag);
    endtask

    initial begin
        instr_t x;
        bit     st, fl;
        int     kind, sel;

        RST_N = 1'b0;
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        tick(); tick();
        check_outs("reset", 32'd0, 5'd0, 0, 0, 0, 5'd0, 32'd0);
        RST_N = 1'b1;

        //          st fl rw mtr mw  alu          wd            wr    alum         wrm  rwm err rwwb wrwb res
        vecs.push_back(v(0, 0, 1, 0, 0, 32'h1234, 32'h0,        5'd5, 32'h1234,    5'd5, 1, 0, 0, 5'd0,  32'h0));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h10,   32'hDEADBEEF, 5'd0, 32'h10,      5'd0, 0, 0, 1, 5'd5,  32'h1234));
        vecs.push_back(v(0, 0, 1, 1, 0, 32'h10,   32'h0,        5'd8, 32'h10,      5'd8, 1, 0, 0, 5'd0,  32'h10));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h12,   32'h11111111, 5'd0, 32'h12,      5'd0, 0, 1, 1, 5'd8,  32'hDEADBEEF));
        vecs.push_back(v(0, 0, 1, 1, 0, 32'h1000, 32'h0,        5'd9, 32'h1000,    5'd9, 1, 1, 0, 5'd0,  32'h12));
        vecs.push_back(v(0, 0, 1, 1, 0, 32'h10,   32'h0,       5'd10, 32'h10,     5'd10, 1, 0, 1, 5'd9,  32'h0));
        vecs.push_back(v(0, 0, 1, 0, 0, 32'h55,   32'h0,        5'd0, 32'h55,      5'd0, 1, 0, 1, 5'd10, 32'hDEADBEEF));
        vecs.push_back(v(0, 1, 1, 0, 0, 32'h77,   32'h0,        5'd3, 32'h0,       5'd0, 0, 0, 0, 5'd0,  32'h55));
        vecs.push_back(v(0, 0, 1, 0, 0, 32'h99,   32'h0,        5'd4, 32'h99,      5'd4, 1, 0, 0, 5'd0,  32'h0));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h20,   32'hCAFEF00D, 5'd0, 32'h20,      5'd0, 0, 0, 1, 5'd4,  32'h99));
        vecs.push_back(v(1, 0, 1, 0, 1, 32'h20,   32'hBAD0BAD0, 5'd7, 32'h20,      5'd0, 0, 0, 1, 5'd4,  32'h99));
        vecs.push_back(v(1, 0, 1, 0, 1, 32'h24,   32'hBAD1BAD1, 5'd7, 32'h20,      5'd0, 0, 0, 1, 5'd4,  32'h99));
        vecs.push_back(v(1, 0, 1, 0, 1, 32'h20,   32'hBAD2BAD2, 5'd7, 32'h20,      5'd0, 0, 0, 1, 5'd4,  32'h99));
        vecs.push_back(v(0, 0, 1, 1, 0, 32'h20,   32'h0,       5'd11, 32'h20,     5'd11, 1, 0, 0, 5'd0,  32'h20));
        vecs.push_back(v(0, 0, 1, 0, 0, 32'h66,   32'h0,       5'd12, 32'h66,     5'd12, 1, 0, 1, 5'd11, 32'hCAFEF00D));
        vecs.push_back(v(1, 1, 1, 0, 0, 32'h44,   32'h0,        5'd6, 32'h0,       5'd0, 0, 0, 1, 5'd12, 32'h66));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].fl, vecs[i].rw, vecs[i].mtr, vecs[i].mw,
                  vecs[i].alu, vecs[i].wd, vecs[i].wr);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_alum, vecs[i].e_wrm, vecs[i].e_rwm,
                       vecs[i].e_err, vecs[i].e_rwwb, vecs[i].e_wrwb, vecs[i].e_res);
        end

        // Asynchronous reset between edges cancels a pending store.
        drive(0, 0, 0, 0, 1, 32'h30, 32'hA5A5A5A5, 5'd0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h30, 32'h5A5A5A5A, 5'd0);
        tick();
        drive(0, 0, 1, 0, 0, 32'h44, 32'h77, 5'd6);
        #2;
        RST_N = 1'b0;
        #1;
        check_outs("async_rst", 32'd0, 5'd0, 0, 0, 0, 5'd0, 32'd0);
        RST_N = 1'b1;
        #1;
        check_outs("rst_release", 32'd0, 5'd0, 0, 0, 0, 5'd0, 32'd0);
        drive(0, 0, 1, 1, 0, 32'h30, 32'h0, 5'd13);
        tick();
        check_outs("post_rst_cap", 32'h30, 5'd13, 1, 0, 0, 5'd0, 32'd0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("cancelled_store.RegWriteWB", 32'(bus.RegWriteWB), 32'd1);
        chk("cancelled_store.WriteRegWB", 32'(bus.WriteRegWB), 32'd13);
        chk("cancelled_store.ResultWB", bus.ResultWB, 32'hA5A5A5A5);

        // Randomized phase against the model, starting from a fresh reset.
        #2;
        RST_N = 1'b0;
        #1;
        RST_N = 1'b1;
        occ = '{default: '0};
        m_we = 1'b0; m_rd = 5'd0; m_res = 32'd0;

        for (int i = 0; i < 16; i++) begin
            x = '{rw: 1'b0, mtr: 1'b0, mw: 1'b1, alu: 32'(i * 4), wd: $urandom, wr: 5'd0};
            run_model_cycle($sformatf("init%0d", i), 1'b0, 1'b0, x);
        end

        for (int i = 0; i < 1500; i++) begin
            st   = ($urandom_range(0, 99) < 20);
            fl   = ($urandom_range(0, 99) < 8);
            kind = $urandom_range(0, 3);
            sel  = $urandom_range(0, 9);
            x.wd = $urandom;
            x.wr = 5'($urandom_range(0, 31));
            if (sel < 7)       x.alu = 32'($urandom_range(0, 15) * 4);
            else if (sel == 7) x.alu = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (sel == 8) x.alu = 32'(MEM_BYTES) + 32'($urandom_range(0, 15) * 4);
            else               x.alu = $urandom | 32'h8000_0000;
            case (kind)
                0: begin x.rw = 1'b1; x.mtr = 1'b0; x.mw = 1'b0; x.alu = $urandom; end
                1: begin x.rw = ($urandom_range(0, 7) != 0); x.mtr = 1'b1; x.mw = 1'b0; end
                2: begin x.rw = 1'b0; x.mtr = 1'b0; x.mw = 1'b1; end
                default: begin x.rw = 1'($urandom_range(0, 1)); x.mtr = 1'b0; x.mw = 1'b0; end
            endcase
            run_model_cycle($sformatf("rnd%0d", i), st, fl, x);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
